seq_mul32: RTL and testbench

SEQ_MUL32 -- requirements
Module: seq_mul32

---
 rtl/seq_mul32_if.sv | 22 ++
 rtl/seq_mul32.sv | 93 +++++++++
 tb/tb_seq_mul32.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mul32_if.sv
// Operand/result handshake bundle for seq_mul32.
// The master drives the operands and out_ready; the slave (the multiplier) returns the status and the product.
interface seq_mul32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_mul32.sv
// 32x32 -> 64 unsigned shift-add multiplier: one partial product per cycle, 32 RUN cycles.
// An optional shortcut sends zero-operand products straight to DONE.
module seq_mul32 #(
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    seq_mul32_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] acc;
    logic [31:0] mcand;
    logic [4:0]  count;
    logic [32:0] sum33;
    logic        zero_op;

    assign zero_op = FAST_ZERO && ((bus.a == '0) || (bus.b == '0));

    // Upper half plus the selected multiplicand; bit 32 carries into acc[63] after the shift.
    assign sum33 = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mcand : 32'h0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                if (count == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.busy      = (state == RUN);
        bus.out_valid = (state == DONE);
        bus.product   = acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand <= bus.a;
                        count <= '0;
                        acc   <= zero_op ? 64'h0 : {32'h0, bus.b};
                    end
                end
                RUN: begin
                    acc <= {sum33, acc[31:1]};
                    // Saturate on the last step so count never wraps inside an operation.
                    if (count != 5'd31) begin
                        count <= count + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul32.sv
// Directed and streaming checks for seq_mul32.
// A second instance with the zero shortcut disabled follows the same stimulus.
module tb_seq_mul32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_mul32_if bus ();
    seq_mul32_if bus_nz ();

    assign bus_nz.in_valid  = bus.in_valid;
    assign bus_nz.a         = bus.a;
    assign bus_nz.b         = bus.b;
    assign bus_nz.out_ready = bus.out_ready;

    seq_mul32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    seq_mul32 #(.FAST_ZERO(1'b0)) dut_nz (
        .clk (clk),
        .rst (rst),
        .bus (bus_nz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one pair, check latency and product, hold out_ready low for `hold` cycles, then handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int hold, input logic [63:0] exp);
        int lat;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        lat = 1;
        if (exp_lat > 1) check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_product"}, bus.product, exp);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            check({tag, "_hold_product"}, bus.product, exp);
            check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_hold_out_valid"}, 64'(bus.out_valid), 64'd1);
        end
        // in_valid stays high across the handshake: DONE must not accept it.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check({tag, "_idle_after"}, {61'h0, bus.in_ready, bus.busy, bus.out_valid}, 64'b100);
    endtask

    initial begin
        int lat;
        int seen;
        int sent;
        int rx;
        int cyc;
        bit acc_pend;
        logic [63:0] q[$];
        logic [63:0] exp_p;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_flags", {61'h0, bus.in_ready, bus.busy, bus.out_valid}, 64'b100);
        check("reset_product", bus.product, 64'h0);

        run_op("basic", 32'd3, 32'd5, 33, 0, 64'd15);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 64'hFFFF_FFFE_0000_0001);
        run_op("times_one", 32'hDEAD_BEEF, 32'd1, 33, 0, 64'h0000_0000_DEAD_BEEF);
        run_op("msb", 32'h8000_0000, 32'h8000_0001, 33, 0, 64'h4000_0000_8000_0000);

        // Zero shortcut versus the full 32-step path on the FAST_ZERO=0 instance.
        bus.in_valid = 1'b1;
        bus.a        = 32'h0;
        bus.b        = 32'h1234;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("zero_fast_valid", 64'(bus.out_valid), 64'd1);
        check("zero_fast_product", bus.product, 64'h0);
        check("zero_slow_busy", 64'(bus_nz.busy), 64'd1);
        lat = 1;
        while (!bus_nz.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("zero_slow_latency", 64'(lat), 64'd33);
        check("zero_slow_product", bus_nz.product, 64'h0);
        check("zero_fast_held", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("zero_both_idle", {62'h0, bus.in_ready, bus_nz.in_ready}, 64'b11);

        run_op("bp", 32'h0001_0000, 32'h0001_0000, 33, 10, 64'h0000_0001_0000_0000);

        // Reset in the middle of RUN.
        bus.in_valid = 1'b1;
        bus.a        = 32'd7;
        bus.b        = 32'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("midrst_flags", {61'h0, bus.in_ready, bus.busy, bus.out_valid}, 64'b100);
        check("midrst_product", bus.product, 64'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        run_op("after_rst", 32'd2, 32'd2, 33, 0, 64'd4);

        // Streaming: in_valid held high, random out_ready, scoreboard in order.
        sent = 0;
        rx = 0;
        cyc = 0;
        acc_pend = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.in_valid = 1'b1;
        while (rx < 100 && cyc < 20000) begin
            if (acc_pend) begin
                bus.a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                bus.b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                if (sent >= 100) bus.in_valid = 1'b0;
            end
            acc_pend = 1'b0;
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                exp_p = (q.size() > 0) ? q.pop_front() : 64'hX;
                check("stream_product", bus.product, exp_p);
                rx++;
            end
            if (bus.in_ready && bus.in_valid) begin
                q.push_back({32'h0, bus.a} * {32'h0, bus.b});
                sent++;
                acc_pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("stream_received", 64'(rx), 64'd100);
        check("stream_sent", 64'(sent), 64'd100);
        check("stream_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
